// File: rtl/box_motion_ctrl.sv
// Player box vertical motion: gravity/jump physics once per frame, erase+draw requests to painter.
// Latency: draw request 1 cycle after reset; per frame erase issued 2 cycles after tick, draw 4+busy cycles later.
// Backpressure: painter busy flag stalls the FSM in WAIT_E/WAIT_D; at most one frame tick is held pending.
module box_motion_ctrl #(
    parameter int FRAME_DIV = 833333,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 112,
    parameter int JUMP_VEL  = 6,
    parameter int GRAVITY   = 1,
    parameter int MAX_FALL  = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       jump,
    input  logic       drawing,
    output logic       draw_box,
    output logic       erase,
    output logic [6:0] box_y,
    output logic       frame_tick,
    output logic       overrun
);

    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
    localparam logic [6:0]        Y_MAX7   = 7'(Y_MAX);
    localparam logic [6:0]        Y_MIN7   = 7'(Y_MIN);
    localparam logic signed [7:0] S_YMAX   = 8'(Y_MAX);
    localparam logic signed [7:0] S_YMIN   = 8'(Y_MIN);
    localparam logic signed [5:0] V_JUMP   = 6'(-JUMP_VEL);
    localparam logic signed [6:0] V_GRAV   = 7'(GRAVITY);
    localparam logic signed [6:0] V_MAXF   = 7'(MAX_FALL);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ERASE  = 3'd1;
    localparam logic [2:0] S_HOLD_E = 3'd2;
    localparam logic [2:0] S_WAIT_E = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;
    localparam logic [2:0] S_DRAW   = 3'd5;
    localparam logic [2:0] S_HOLD_D = 3'd6;
    localparam logic [2:0] S_WAIT_D = 3'd7;

    logic [DIV_W-1:0]  div_q, div_d;
    logic [2:0]        state_q, state_d;
    logic [6:0]        y_q, y_d;
    logic signed [5:0] vel_q, vel_d;
    logic [6:0]        box_y_q, box_y_d;
    logic              overrun_q, overrun_d;
    logic              tick_pend_q, tick_pend_d;
    logic              jump_pend_q, jump_pend_d;
    logic              jump_prev_q;

    logic              tick_w;
    logic signed [5:0] v_sel;
    logic signed [7:0] s_sum;
    logic signed [6:0] v_inc;
    logic [6:0]        y_upd;
    logic signed [5:0] vel_upd;

    // Frame divider wraps at FRAME_DIV-1; the wrap cycle is the frame tick.
    assign tick_w = (div_q == DIV_LAST);
    assign div_d  = tick_w ? '0 : div_q + 1'b1;

    // Outputs are forced low while reset is held so no request leaks during reset.
    assign draw_box   = ~reset & ((state_q == S_ERASE) | (state_q == S_DRAW));
    assign erase      = ~reset & (state_q == S_ERASE);
    assign frame_tick = ~reset & tick_w;
    assign box_y      = box_y_q;
    assign overrun    = overrun_q;

    // Tick/jump bookkeeping: a new tick or jump edge wins over a same-cycle clear.
    always_comb begin
        tick_pend_d = tick_pend_q;
        overrun_d   = overrun_q | (tick_w & tick_pend_q);
        jump_pend_d = jump_pend_q;
        if ((state_q == S_IDLE) && tick_pend_q) begin
            tick_pend_d = 1'b0;
        end
        if (tick_w) begin
            tick_pend_d = 1'b1;
        end
        if (state_q == S_UPDATE) begin
            jump_pend_d = 1'b0;
        end
        if (jump && !jump_prev_q) begin
            jump_pend_d = 1'b1;
        end
    end

    // Physics step: jump only from the ground, sum at 8-bit signed so it cannot wrap, clamp to [Y_MIN, Y_MAX].
    always_comb begin
        v_sel   = (jump_pend_q && (y_q == Y_MAX7)) ? V_JUMP : vel_q;
        s_sum   = $signed({1'b0, y_q}) + $signed({{2{v_sel[5]}}, v_sel});
        v_inc   = $signed({v_sel[5], v_sel}) + V_GRAV;
        y_upd   = s_sum[6:0];
        vel_upd = (v_inc > V_MAXF) ? V_MAXF[5:0] : v_inc[5:0];
        if (s_sum >= S_YMAX) begin
            y_upd   = Y_MAX7;
            vel_upd = '0;
        end else if (s_sum <= S_YMIN) begin
            y_upd   = Y_MIN7;
            vel_upd = '0;
        end
    end

    // Request sequencer: erase old box, wait for painter, update physics, draw new box, wait again.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        vel_d   = vel_q;
        box_y_d = box_y_q;
        case (state_q)
            S_IDLE: begin
                if (tick_pend_q) begin
                    state_d = S_ERASE;
                    box_y_d = y_q;
                end
            end
            S_ERASE:  state_d = S_HOLD_E;
            S_HOLD_E: state_d = S_WAIT_E;
            S_WAIT_E: if (!drawing) state_d = S_UPDATE;
            S_UPDATE: begin
                state_d = S_DRAW;
                y_d     = y_upd;
                vel_d   = vel_upd;
                box_y_d = y_upd;
            end
            S_DRAW:   state_d = S_HOLD_D;
            S_HOLD_D: state_d = S_WAIT_D;
            S_WAIT_D: if (!drawing) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State registers; reset restarts with a fresh draw of the box on the ground.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q       <= '0;
            state_q     <= S_DRAW;
            y_q         <= Y_MAX7;
            vel_q       <= '0;
            box_y_q     <= Y_MAX7;
            overrun_q   <= 1'b0;
            tick_pend_q <= 1'b0;
            jump_pend_q <= 1'b0;
            jump_prev_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            state_q     <= state_d;
            y_q         <= y_d;
            vel_q       <= vel_d;
            box_y_q     <= box_y_d;
            overrun_q   <= overrun_d;
            tick_pend_q <= tick_pend_d;
            jump_pend_q <= jump_pend_d;
            jump_prev_q <= jump;
        end
    end

endmodule

// File: tb/tb_box_motion_ctrl.sv
// Directed bench for box_motion_ctrl with a painter model driving the busy flag.
// Latency: checks request cycles relative to reset/ticks; painter busy length is programmable.
// Backpressure: painter can hold drawing high for a programmable length or indefinitely.
module tb_box_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       jump = 1'b0;
    logic       drawing = 1'b0;
    logic       draw_box;
    logic       erase;
    logic [6:0] box_y;
    logic       frame_tick;
    logic       overrun;

    box_motion_ctrl #(.FRAME_DIV(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .jump       (jump),
        .drawing    (drawing),
        .draw_box   (draw_box),
        .erase      (erase),
        .box_y      (box_y),
        .frame_tick (frame_tick),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Painter model and request log.
    int busy_len  = 0;
    int busy_cnt  = 0;
    bit hold_busy = 1'b0;
    int cyc       = 0;
    bit prev_draw = 1'b0;
    int p_cyc[$];
    int p_er[$];
    int p_y[$];
    int t_cyc[$];

    int traj[14] = '{106, 101, 97, 94, 92, 91, 91, 92, 94, 97, 101, 106, 112, 112};

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_log();
        p_cyc.delete();
        p_er.delete();
        p_y.delete();
        t_cyc.delete();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset) cyc = 0;
            else       cyc++;
            if (busy_cnt > 0) begin
                drawing = 1'b1;
                busy_cnt--;
            end else begin
                drawing = hold_busy;
            end
            if (frame_tick) t_cyc.push_back(cyc);
            if (erase) check_eq("erase_without_draw_box", int'(draw_box), 1);
            if (draw_box) begin
                check_eq("draw_box_back_to_back", int'(prev_draw), 0);
                p_cyc.push_back(cyc);
                p_er.push_back(int'(erase));
                p_y.push_back(int'(box_y));
                busy_cnt = busy_len;
            end
            prev_draw = draw_box;
        end
    end

    task automatic wait_pulses(input int n, input int budget, input string tag);
        int k = 0;
        while (p_y.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        #1;
        check_eq(tag, p_y.size() >= n, 1);
    endtask

    // Align to the end of a frame: wait for a draw request, then clear the log.
    task automatic sync_draw();
        int  k = 0;
        bit  found = 1'b0;
        while (!found && k < 200) begin
            @(negedge clk);
            k++;
            found = draw_box && !erase;
        end
        check_eq("sync_draw_found", int'(found), 1);
        @(posedge clk);
        #1;
        clear_log();
    endtask

    task automatic pulse_jump();
        jump = 1'b1;
        @(posedge clk);
        #1;
        jump = 1'b0;
    endtask

    task automatic check_traj(input string tag);
        for (int i = 0; i < 14; i++) begin
            check_eq({tag, "_erase_flag"}, p_er[2*i], 1);
            check_eq({tag, "_erase_y"}, p_y[2*i], (i == 0) ? 112 : traj[i-1]);
            check_eq({tag, "_draw_flag"}, p_er[2*i+1], 0);
            check_eq({tag, "_draw_y"}, p_y[2*i+1], traj[i]);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_draw_box", int'(draw_box), 0);
        check_eq("rst_erase", int'(erase), 0);
        check_eq("rst_frame_tick", int'(frame_tick), 0);
        check_eq("rst_overrun", int'(overrun), 0);
        check_eq("rst_box_y", int'(box_y), 112);

        // First cycle after reset draws the box on the ground; next requests follow ticks.
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_rst_draw_box", int'(draw_box), 1);
        check_eq("post_rst_erase", int'(erase), 0);
        check_eq("post_rst_box_y", int'(box_y), 112);
        repeat (39) @(negedge clk);
        #1;
        check_eq("idle_pulse_count", p_cyc.size(), 5);
        check_eq("idle_p0_cyc", p_cyc[0], 1);
        check_eq("idle_p1_cyc", p_cyc[1], 18);
        check_eq("idle_p1_erase", p_er[1], 1);
        check_eq("idle_p2_cyc", p_cyc[2], 22);
        check_eq("idle_p2_erase", p_er[2], 0);
        check_eq("idle_p3_cyc", p_cyc[3], 34);
        check_eq("idle_p4_cyc", p_cyc[4], 38);
        for (int i = 1; i < 5; i++) check_eq("idle_y", p_y[i], 112);
        check_eq("tick_count", t_cyc.size(), 2);
        check_eq("tick0_cyc", t_cyc[0], 16);
        check_eq("tick_period", t_cyc[1] - t_cyc[0], 16);

        // Painter busy for 3 cycles after each request: requests wait for drawing to fall.
        busy_len = 3;
        sync_draw();
        wait_pulses(4, 100, "busy3_timeout");
        check_eq("busy3_er0", p_er[0], 1);
        check_eq("busy3_er1", p_er[1], 0);
        check_eq("busy3_gap0", p_cyc[1] - p_cyc[0], 6);
        check_eq("busy3_gap1", p_cyc[3] - p_cyc[2], 6);
        for (int i = 0; i < 4; i++) check_eq("busy3_y", p_y[i], 112);

        // Single jump: full trajectory, then back on the ground.
        sync_draw();
        pulse_jump();
        wait_pulses(28, 600, "jump_timeout");
        check_traj("jump");

        // Jump pressed while airborne at y=101 is ignored.
        sync_draw();
        pulse_jump();
        wait_pulses(4, 200, "air_first_timeout");
        pulse_jump();
        wait_pulses(28, 600, "air_timeout");
        check_traj("air");

        // Jump held high: only one jump until released and pressed again.
        sync_draw();
        jump = 1'b1;
        wait_pulses(32, 700, "held_timeout");
        for (int i = 0; i < 16; i++)
            check_eq("held_draw_y", p_y[2*i+1], (i < 13) ? traj[i] : 112);
        jump = 1'b0;
        sync_draw();
        jump = 1'b1;
        wait_pulses(2, 100, "repress_timeout");
        check_eq("repress_draw_y", p_y[1], 106);
        jump = 1'b0;
        wait_pulses(28, 600, "repress_land_timeout");

        // Painter stuck for 40 cycles: one pending tick serviced, overrun sticky.
        busy_len = 0;
        check_eq("overrun_before", int'(overrun), 0);
        begin
            int  k = 0;
            bit  found = 1'b0;
            while (!found && k < 200) begin
                @(negedge clk);
                k++;
                found = erase;
            end
            check_eq("sync_erase_found", int'(found), 1);
        end
        @(posedge clk);
        #1;
        clear_log();
        hold_busy = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        hold_busy = 1'b0;
        check_eq("stall_no_pulses", p_y.size(), 0);
        repeat (14) @(negedge clk);
        #1;
        check_eq("stall_pulse_count", p_y.size(), 3);
        check_eq("stall_p0_erase", p_er[0], 0);
        check_eq("stall_p1_erase", p_er[1], 1);
        check_eq("stall_p2_erase", p_er[2], 0);
        check_eq("overrun_set", int'(overrun), 1);
        repeat (20) @(negedge clk);
        check_eq("overrun_sticky", int'(overrun), 1);

        // Reset in the middle of WAIT_D while airborne.
        busy_len = 10;
        sync_draw();
        pulse_jump();
        wait_pulses(2, 200, "rst_mid_timeout");
        check_eq("rst_mid_draw_y", p_y[1], 106);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_draw_box", int'(draw_box), 1);
        check_eq("rst_mid_erase", int'(erase), 0);
        check_eq("rst_mid_box_y", int'(box_y), 112);
        check_eq("rst_mid_overrun", int'(overrun), 0);
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/box_motion_ctrl.md
Name: box_motion_ctrl

Overview:
- Upstream stage of the painter. Owns the player box's vertical position and runs gravity/jump physics once per video frame.
- Each frame it requests an erase of the old box, then a draw of the new box. Requests go to the painter over a pulse/busy handshake.
- Output coordinates use the painter's 160x120 pixel space; y is 7 bits.

Parameters:
FRAME_DIV, 833333, clk cycles per frame tick (50 MHz / 60 Hz); sims use 16
Y_MIN, 0, top-most legal box_y
Y_MAX, 112, bottom-most legal box_y (ground; 8-row box)
JUMP_VEL, 6, upward speed applied on jump, px/frame
GRAVITY, 1, velocity increment per frame, px/frame
MAX_FALL, 7, downward velocity saturation, px/frame

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
jump  in  1  player jump button, level, already synchronised
drawing  in  1  painter busy flag; high while a box operation is in progress
draw_box  out  1  one-cycle request pulse to painter
erase  out  1  qualifies draw_box: 1 = paint background, 0 = paint box colour; valid only with draw_box
box_y  out  7  y coordinate for the current request; stable from the pulse until the next pulse
frame_tick  out  1  one-cycle pulse every FRAME_DIV cycles
overrun  out  1  sticky; set when a frame tick arrives while one is already pending

Behaviour:
- Reset (sync, active-high, overrides everything):
  - Divider = 0, state = DRAW, box_y = Y_MAX, vel = 0.
  - draw_box = 0, erase = 0, frame_tick = 0, overrun = 0.
  - jump_pend = 0, tick_pend = 0, jump_prev = 0.
  - Reset asserted mid-handshake abandons the operation; no erase is issued for the abandoned box.
- Frame divider:
  - Counts 0..FRAME_DIV-1 and wraps.
  - frame_tick is high for the one cycle the count equals FRAME_DIV-1.
  - Each tick sets tick_pend. If tick_pend is already 1, overrun is set (sticky until reset). Ticks never queue beyond one.
- Jump capture: a rising edge of jump (jump & ~jump_prev) sets jump_pend. jump_pend clears only in UPDATE.
- vel is a 6-bit signed register; positive means downward.
- States:
  - IDLE: draw_box = 0. If tick_pend, clear it and go to ERASE.
  - ERASE: draw_box = 1, erase = 1, box_y = current y, for exactly one cycle; then go to HOLD_E.
  - HOLD_E: drawing is ignored for this cycle (painter's flag may lag by one); go to WAIT_E.
  - WAIT_E: stay while drawing = 1; go to UPDATE when drawing = 0.
  - UPDATE (one cycle):
    - If jump_pend and y == Y_MAX, v = -JUMP_VEL; else v = vel. Clear jump_pend either way.
    - Compute s = y + v at 8-bit signed width.
    - If s >= Y_MAX: y = Y_MAX, vel = 0.
    - Else if s <= Y_MIN: y = Y_MIN, vel = 0.
    - Else: y = s, vel = min(v + GRAVITY, MAX_FALL).
    - Go to DRAW.
  - DRAW: draw_box = 1, erase = 0, box_y = new y, for exactly one cycle; then go to HOLD_D.
  - HOLD_D: same as HOLD_E; go to WAIT_D.
  - WAIT_D: same as WAIT_E; go to IDLE.
- A tick and a state transition in the same cycle: the tick is latched into tick_pend and serviced on the next IDLE.
- A jump edge in the UPDATE cycle is captured after the clear and applies next frame.
- Jump while airborne (y != Y_MAX) is discarded at UPDATE.
- draw_box is never high on two consecutive cycles. erase is 0 whenever draw_box is 0.
- Box never leaves [Y_MIN, Y_MAX]; no wrap-around of box_y.

Test Plan:
- Reset with FRAME_DIV=16 and drawing held 0 -> first cycle after reset has draw_box=1, erase=0, box_y=112. No further request until frame_tick at cycle 16. frame_tick period is exactly 16.
- Idle at ground, no jump, drawing pulses high 3 cycles after each request -> per frame: erase@112, draw@112. vel stays 0. Each request waits for drawing to fall.
- Jump edge between ticks -> next frames draw y = 106, 101, 97, 94, 92, 91, 91, 92, 94, 97, 101, 106, 112 (apex then fall; vel saturates at 7 if longer). Then stays at 112.
- Jump held high across many frames -> only one jump occurs. Second jump requires release then press.
- Jump pressed at y=101 while airborne -> ignored; trajectory unchanged.
- drawing held high for 40 cycles (>2 frames) -> one pending tick serviced afterwards. overrun = 1 and remains 1. Reset mid-WAIT_D -> draw_box=1, erase=0, y=112 on first post-reset cycle and overrun cleared.
